// File: rtl/instr_mem_pkg.sv
// Shared types and default sizing for the loadable instruction memory.
// Imported by the memory top level and its RAM.
package instr_mem_pkg;

    typedef enum logic {
        ST_RUN,
        ST_LOAD
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 256;

endpackage

// File: rtl/instr_ram.sv
// Single-port-write, single-port-read RAM with a registered read output.
// Only the read register is reset; the array keeps its contents.
module instr_ram
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds its value when no read is issued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_instruction_memory.sv
// Instruction memory with a run-time program-load port and a
// one-cycle registered fetch port for the CPU.
module prog_instruction_memory
    import instr_mem_pkg::*;
#(
    parameter int                 DATA_W     = DEF_DATA_W,
    parameter int                 ADDR_W     = DEF_ADDR_W,
    parameter int                 DEPTH      = DEF_DEPTH,
    parameter logic [DATA_W-1:0]  FILL_VALUE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instruction,
    output logic              fetch_err
);

    localparam int RAM_AW = $clog2(DEPTH);
    localparam logic [RAM_AW-1:0] LAST_PTR = RAM_AW'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [RAM_AW-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   beats_q, beats_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              valid_q, err_q, fill_q;
    logic              we;
    logic              fetch_acc;
    logic              fetch_oor;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    assign load_ready  = (state_q == ST_LOAD);
    assign fetch_ready = (state_q == ST_RUN);

    assign fetch_acc = fetch_req & fetch_ready;
    assign fetch_oor = ({1'b0, fetch_addr} >= DEPTH_W);
    assign ram_re    = fetch_acc & ~fetch_oor;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        beats_d = beats_q;
        count_d = count_q;
        done_d  = 1'b0;
        we      = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    beats_d = '0;
                end
            end
            ST_LOAD: begin
                // A restart discards any beat presented alongside it.
                if (load_start) begin
                    ptr_d   = '0;
                    beats_d = '0;
                end else if (load_valid) begin
                    we      = ~reset;
                    ptr_d   = ptr_q + 1'b1;
                    beats_d = beats_q + ONE_CNT;
                    if (load_last || ptr_q == LAST_PTR) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                        count_d = beats_q + ONE_CNT;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            beats_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            beats_q <= beats_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // fill_q remembers whether the held word is the fill value.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            valid_q <= fetch_acc;
            err_q   <= fetch_acc & fetch_oor;
            if (fetch_acc) begin
                fill_q <= fetch_oor;
            end
        end
    end

    instr_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (reset),
        .we_i    (we),
        .waddr_i (ptr_q),
        .wdata_i (load_data),
        .re_i    (ram_re),
        .raddr_i (fetch_addr[RAM_AW-1:0]),
        .rdata_o (ram_rdata)
    );

    assign load_done   = done_q;
    assign load_count  = count_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;
    assign instruction = fill_q ? FILL_VALUE : ram_rdata;

endmodule
